// File: rtl/snake_key_decoder_if.sv
// -----------------------------------------------------------------------------
// snake_key_decoder_if
// Bundles the scan-code input and the outputs of the snake key decoder.
//   scan_code    [7:0]  received scan-code byte
//   scan_valid          one-cycle strobe, one byte per high cycle
//   dir_ready           game logic accepts the FIFO head
//   dir_valid           direction FIFO not empty
//   dir          [1:0]  FIFO head (00 up, 01 down, 10 left, 11 right), 00 when empty
//   pause_toggle        one-cycle pulse on a fresh Space make
//   restart             one-cycle pulse on a fresh Esc make
//   overflow            sticky: a command was dropped because the FIFO was full
//   keys_held    [3:0]  {right,left,down,up} direction keys currently held
// master: the side feeding bytes and draining commands; slave: the decoder.
// -----------------------------------------------------------------------------
interface snake_key_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       dir_ready;
  logic       dir_valid;
  logic [1:0] dir;
  logic       pause_toggle;
  logic       restart;
  logic       overflow;
  logic [3:0] keys_held;

  modport master (
    output scan_code, scan_valid, dir_ready,
    input  dir_valid, dir, pause_toggle, restart, overflow, keys_held
  );

  modport slave (
    input  scan_code, scan_valid, dir_ready,
    output dir_valid, dir, pause_toggle, restart, overflow, keys_held
  );
endinterface

// File: rtl/snake_key_decoder.sv
// -----------------------------------------------------------------------------
// snake_key_decoder
// Parses PS/2 set-2 make/break/E0 sequences, suppresses typematic repeats and
// turns arrow keys into filtered snake direction commands queued in a FIFO.
// Space and Esc produce pause_toggle / restart pulses.
// Ports:
//   clk      50 MHz system clock
//   reset_n  synchronous reset, active-low
//   bus      snake_key_decoder_if.slave (scan input, command FIFO, status)
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   INIT_DIR    reference direction after reset / restart
// Optional feature: define WASD_KEYS_EN to also accept W/S/A/D (1D/1B/1C/23).
// -----------------------------------------------------------------------------
module snake_key_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_DIR   = 2'b11
) (
  input logic               clk,
  input logic               reset_n,
  snake_key_decoder_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Key slots: 0..3 arrows (up,down,left,right), 4 Space, 5 Esc, 6..9 WASD.
  localparam int K_SPACE = 4;
  localparam int K_ESC   = 5;
`ifdef WASD_KEYS_EN
  localparam int W_BASE  = 6;
  localparam int NKEYS   = 10;
`else
  localparam int NKEYS   = 6;
`endif

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_t;

  parse_state_t state, state_next;
  logic         key_make, key_break, key_ext;
  logic [NKEYS-1:0] key_sel, held, fresh_sel;
  logic         cand_valid;
  logic [1:0]   cand_dir;
  logic [1:0]   last_dir;
  logic         restart_hit, accept, push, pop, empty, full;
  logic [1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic         pause_q, restart_q, overflow_q;

  // ---------------- parser FSM: state register ----------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------- parser FSM: next state ----------------
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (bus.scan_valid) begin
      unique case (state)
        IDLE: begin
          if (bus.scan_code == 8'hE0)      state_next = EXT;
          else if (bus.scan_code == 8'hF0) state_next = BRK;
        end
        EXT: begin
          if (bus.scan_code == 8'hF0)      state_next = EXT_BRK;
          else if (bus.scan_code != 8'hE0) state_next = IDLE;
        end
        BRK, EXT_BRK: state_next = IDLE;
      endcase
    end
  end

  // ---------------- parser FSM: decoded key events ----------------
  always_comb begin
    key_make  = 1'b0;
    key_break = 1'b0;
    key_ext   = 1'b0;
    if (bus.scan_valid) begin
      unique case (state)
        // E1 (Pause prefix) is swallowed without producing an event.
        IDLE: key_make = !(bus.scan_code inside {8'hE0, 8'hF0, 8'hE1});
        EXT: begin
          key_make = !(bus.scan_code inside {8'hE0, 8'hF0});
          key_ext  = 1'b1;
        end
        BRK: key_break = 1'b1;
        EXT_BRK: begin
          key_break = 1'b1;
          key_ext   = 1'b1;
        end
      endcase
    end
  end

  // ---------------- key map ----------------
  always_comb begin
    key_sel = '0;
    if (key_ext) begin
      case (bus.scan_code)
        8'h75:   key_sel[0] = 1'b1;
        8'h72:   key_sel[1] = 1'b1;
        8'h6B:   key_sel[2] = 1'b1;
        8'h74:   key_sel[3] = 1'b1;
        default: ;
      endcase
    end else begin
      case (bus.scan_code)
        8'h29:   key_sel[K_SPACE] = 1'b1;
        8'h76:   key_sel[K_ESC]   = 1'b1;
`ifdef WASD_KEYS_EN
        8'h1D:   key_sel[W_BASE+0] = 1'b1;
        8'h1B:   key_sel[W_BASE+1] = 1'b1;
        8'h1C:   key_sel[W_BASE+2] = 1'b1;
        8'h23:   key_sel[W_BASE+3] = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // A make only acts when its key was not already held (typematic filter).
  assign fresh_sel   = key_make ? (key_sel & ~held) : '0;
  assign restart_hit = fresh_sel[K_ESC];

  always_comb begin
    cand_valid = 1'b0;
    cand_dir   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (fresh_sel[i]) begin
        cand_valid = 1'b1;
        cand_dir   = 2'(i);
      end
`ifdef WASD_KEYS_EN
      if (fresh_sel[W_BASE+i]) begin
        cand_valid = 1'b1;
        cand_dir   = 2'(i);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)       held <= '0;
    else if (key_make)  held <= held | key_sel;
    else if (key_break) held <= held & ~key_sel;
  end

  // ---------------- command filter and FIFO ----------------
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign pop    = !empty && bus.dir_ready;
  // Repeats of the current heading and 180-degree reversals are discarded.
  assign accept = cand_valid && (cand_dir != last_dir) && (cand_dir != (last_dir ^ 2'b01));
  // A full FIFO still takes the push when it is popped on the same edge.
  assign push   = accept && (!full || pop);

  // NOTE: the storage array has no reset; count/pointers alone define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand_dir;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_dir   <= INIT_DIR;
      overflow_q <= 1'b0;
    end else if (restart_hit) begin
      // Flush wins over any concurrent pop; Esc never carries a direction.
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_dir   <= INIT_DIR;
      overflow_q <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_dir <= cand_dir;
      end
      if (accept && !push) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      pause_q   <= fresh_sel[K_SPACE];
      restart_q <= restart_hit;
    end
  end

  // ---------------- outputs ----------------
  assign bus.dir_valid    = !empty;
  assign bus.dir          = empty ? 2'b00 : mem[rd_ptr];
  assign bus.pause_toggle = pause_q;
  assign bus.restart      = restart_q;
  assign bus.overflow     = overflow_q;
`ifdef WASD_KEYS_EN
  assign bus.keys_held    = held[3:0] | held[W_BASE+3:W_BASE];
`else
  assign bus.keys_held    = held[3:0];
`endif

endmodule

// File: tb/tb_snake_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_snake_key_decoder
// Self-checking bench for snake_key_decoder: a directed vector table, short
// hand-written corner-case sequences and random byte streams, all compared
// against a prefix/queue based reference model.
// -----------------------------------------------------------------------------
module tb_snake_key_decoder;

  localparam int         DEPTH = 4;
  localparam logic [1:0] INIT  = 2'b11;

  logic clk = 1'b0;
  logic reset_n;

  snake_key_decoder_if bus();

  snake_key_decoder #(.FIFO_DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int         q[$];
  logic [7:0] pfx[$];
  bit         m_held [512];
  logic [1:0] m_last;
  bit         m_ovf, m_restart, m_pause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dir_of(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end else begin
`ifdef WASD_KEYS_EN
      if (b == 8'h1D) return 0;
      if (b == 8'h1B) return 1;
      if (b == 8'h1C) return 2;
      if (b == 8'h23) return 3;
`endif
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_keys();
    logic [3:0] k;
    k[0] = m_held[{1'b1, 8'h75}];
    k[1] = m_held[{1'b1, 8'h72}];
    k[2] = m_held[{1'b1, 8'h6B}];
    k[3] = m_held[{1'b1, 8'h74}];
`ifdef WASD_KEYS_EN
    k[0] = k[0] | m_held[{1'b0, 8'h1D}];
    k[1] = k[1] | m_held[{1'b0, 8'h1B}];
    k[2] = k[2] | m_held[{1'b0, 8'h1C}];
    k[3] = k[3] | m_held[{1'b0, 8'h23}];
`endif
    return k;
  endfunction

  task automatic model_reset();
    q.delete();
    pfx.delete();
    for (int i = 0; i < 512; i++) m_held[i] = 1'b0;
    m_last    = INIT;
    m_ovf     = 1'b0;
    m_restart = 1'b0;
    m_pause   = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
    bit pop, ev, ext, brk, fresh;
    int d;
    pop       = (q.size() > 0) && rdy;
    m_restart = 1'b0;
    m_pause   = 1'b0;
    ev = 1'b0; ext = 1'b0; brk = 1'b0; fresh = 1'b0; d = -1;
    if (v) begin
      if (pfx.size() == 0 && b == 8'hE1) begin
        // Pause-key prefix: ignored
      end else if (b == 8'hE0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
        pfx.delete();
        pfx.push_back(8'hE0);
      end else if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
        pfx.push_back(8'hF0);
      end else begin
        ev = 1'b1;
        foreach (pfx[i]) begin
          if (pfx[i] == 8'hE0) ext = 1'b1;
          if (pfx[i] == 8'hF0) brk = 1'b1;
        end
        pfx.delete();
      end
    end
    if (ev) begin
      fresh = !brk && !m_held[{ext, b}];
      m_held[{ext, b}] = !brk;
      if (fresh) begin
        if (!ext && b == 8'h76) m_restart = 1'b1;
        if (!ext && b == 8'h29) m_pause   = 1'b1;
        d = dir_of(ext, b);
      end
    end
    if (m_restart) begin
      q.delete();
      m_last = INIT;
      m_ovf  = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (d >= 0 && 2'(d) != m_last && 2'(d) != (m_last ^ 2'b01)) begin
        if (q.size() < DEPTH) begin
          q.push_back(d);
          m_last = 2'(d);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("dir_valid",    bus.dir_valid,    (q.size() > 0));
    check("dir",          bus.dir,          (q.size() > 0) ? q[0] : 0);
    check("overflow",     bus.overflow,     m_ovf);
    check("keys_held",    bus.keys_held,    m_keys());
    check("restart",      bus.restart,      m_restart);
    check("pause_toggle", bus.pause_toggle, m_pause);
  endtask

  // One clock: drive inputs, let the DUT and model take the edge, compare.
  task automatic tick(input bit v, input logic [7:0] b, input bit rdy);
    bus.scan_valid = v;
    bus.scan_code  = b;
    bus.dir_ready  = rdy;
    @(posedge clk);
    model_step(v, b, rdy);
    #1;
    compare_model();
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.dir_ready  = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset_n = 1'b1;
    compare_model();
  endtask

  task automatic key(input logic [7:0] b, input bit rdy);
    tick(1'b1, 8'hE0, rdy);
    tick(1'b1, b, rdy);
  endtask

  task automatic press_release(input logic [7:0] b, input bit rdy);
    key(b, rdy);
    tick(1'b1, 8'hE0, rdy);
    tick(1'b1, 8'hF0, rdy);
    tick(1'b1, b, rdy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    bit         v;
    logic [7:0] code;
    bit         rdy;
    bit         e_valid;
    logic [1:0] e_dir;
    logic [3:0] e_held;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [1:0] pop_exp[4];
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.dir_ready  = 1'b0;
    reset_n        = 1'b0;

    // up press -> immediate push of 00; release; pop; then right/left dropped, down accepted
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'b0000};
    vt[1]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 2'b00, 4'b0000};
    vt[2]  = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 2'b00, 4'b0001};
    vt[3]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b1, 2'b00, 4'b0001};
    vt[4]  = '{1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 2'b00, 4'b0001};
    vt[5]  = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 2'b00, 4'b0000};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 4'b0000};
    vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'b0000};
    vt[8]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 2'b00, 4'b0000};
    vt[9]  = '{1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 2'b00, 4'b1000};
    vt[10] = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 2'b00, 4'b1000};
    vt[11] = '{1'b0, 1'b1, 8'h6B, 1'b0, 1'b0, 2'b00, 4'b1100};
    vt[12] = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 2'b00, 4'b1100};
    vt[13] = '{1'b0, 1'b1, 8'h72, 1'b0, 1'b1, 2'b01, 4'b1110};

    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      if (vt[i].rst) apply_reset();
      else           tick(vt[i].v, vt[i].code, vt[i].rdy);
      check($sformatf("vec%0d_valid", i), bus.dir_valid, vt[i].e_valid);
      check($sformatf("vec%0d_dir", i),   bus.dir,       vt[i].e_dir);
      check($sformatf("vec%0d_held", i),  bus.keys_held, vt[i].e_held);
    end

    // Typematic repeats: exactly one push, held bit clears on the break.
    apply_reset();
    for (int i = 0; i < 5; i++) key(8'h75, 1'b0);
    tick(1'b1, 8'hE0, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h75, 1'b0);
    check("typ_valid", bus.dir_valid, 1'b1);
    check("typ_dir",   bus.dir,       2'b00);
    check("typ_held",  bus.keys_held, 4'b0000);
    tick(1'b0, 8'h00, 1'b1);
    check("typ_single_push", bus.dir_valid, 1'b0);

    // Fill to depth, fifth command dropped with overflow, then drain in order.
    apply_reset();
    press_release(8'h75, 1'b0);
    press_release(8'h6B, 1'b0);
    press_release(8'h72, 1'b0);
    press_release(8'h74, 1'b0);
    check("ovf_before", bus.overflow, 1'b0);
    press_release(8'h75, 1'b0);
    check("ovf_set",    bus.overflow, 1'b1);
    check("ovf_valid",  bus.dir_valid, 1'b1);
    pop_exp = '{2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pop%0d", i), bus.dir, pop_exp[i]);
      tick(1'b0, 8'h00, 1'b1);
    end

    // Restart with two entries queued: flush, clear overflow, reset heading.
    tick(1'b1, 8'h76, 1'b1);
    check("rst_pulse",    bus.restart,   1'b1);
    check("rst_flush",    bus.dir_valid, 1'b0);
    check("rst_ovf_clr",  bus.overflow,  1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("rst_one_cycle", bus.restart,  1'b0);
    key(8'h74, 1'b0);
    check("rst_init_dir", bus.dir_valid, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h76, 1'b0);

    // Full-FIFO drain order after refilling from INIT heading.
    apply_reset();
    press_release(8'h75, 1'b0);
    press_release(8'h6B, 1'b0);
    press_release(8'h72, 1'b0);
    press_release(8'h74, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), bus.dir, pop_exp[i]);
      tick(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", bus.dir_valid, 1'b0);

    // Reset in the middle of E0,F0 discards the prefix: 75 becomes keypad 8.
    apply_reset();
    tick(1'b1, 8'hE0, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    apply_reset();
    tick(1'b1, 8'h75, 1'b0);
    check("midrst_no_push", bus.dir_valid, 1'b0);
    check("midrst_no_held", bus.keys_held, 4'b0000);

    // Space break before any make: pause only on the real make.
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h29, 1'b0);
    check("pause_on_break", bus.pause_toggle, 1'b0);
    tick(1'b1, 8'h29, 1'b0);
    check("pause_on_make",  bus.pause_toggle, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check("pause_one_cycle", bus.pause_toggle, 1'b0);

    // Random byte streams against the model.
    begin
      logic [7:0] pool[16];
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29,
               8'h76, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hAA, 8'hE0, 8'hF0};
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) apply_reset();
        else tick($urandom_range(0, 3) != 0, pool[$urandom_range(0, 15)],
                  $urandom_range(0, 2) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
